// File: rtl/types_pkg.sv
// Shared types and address helper for the DRAM store arbiter.
// Optional feature macro: DRAMSTORE_ARB_PERF_EN (perf counters on the top).
package types_pkg;

    localparam logic [31:0] STRIDE = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  rsvd;
        logic [1:0]  row;
        logic [63:0] data;
    } dramstore_rec_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dsarb_state_t;

    // Strided row address; product and sum deliberately wrap at 32 bits.
    function automatic logic [31:0] calc_store_addr(input logic [31:0] base,
                                                    input logic [1:0]  row);
        return base + (STRIDE * {30'd0, row});
    endfunction

endpackage

// File: rtl/dramstore_arbiter_if.sv
// FIFO-side and store-port signals of the DRAM store arbiter.
// master = arbiter side, slave = FIFOs/memory side.
interface dramstore_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int REC_W  = 100
);
    logic [3:0]             fifo_empty;
    logic [3:0][REC_W-1:0]  fifo_rdata;
    logic [3:0]             fifo_REN;
    logic                   sStore_hit;
    logic                   sStore;
    logic [ADDR_W-1:0]      store_addr;
    logic [DATA_W-1:0]      store_data;

    modport master (
        input  fifo_empty, fifo_rdata, sStore_hit,
        output fifo_REN, sStore, store_addr, store_data
    );

    modport slave (
        output fifo_empty, fifo_rdata, sStore_hit,
        input  fifo_REN, sStore, store_addr, store_data
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin grant: first set request at or above ptr,
// wrapping 3 -> 0.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       any
);
    logic [3:0] rot_s;
    logic [1:0] off_s;

    // Rotate requests so that the pointer position lands at bit 0.
    always_comb begin
        rot_s = req;
        case (ptr)
            2'd0:    rot_s = req;
            2'd1:    rot_s = {req[0],   req[3:1]};
            2'd2:    rot_s = {req[1:0], req[3:2]};
            2'd3:    rot_s = {req[2:0], req[3]};
            default: rot_s = req;
        endcase
    end

    // Priority-encode the rotated vector into an offset from the pointer.
    always_comb begin
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
    end

    assign any        = |req;
    assign gnt_idx    = ptr + off_s;
    assign gnt_onehot = any ? (4'b0001 << gnt_idx) : 4'b0000;

endmodule

// File: rtl/dramstore_arbiter.sv
// Round-robin, one-outstanding store sequencer draining four DRAM store FIFOs.
// Define DRAMSTORE_ARB_PERF_EN to add perf_stores / perf_stall counters.
module dramstore_arbiter
    import types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int REC_W  = 100
) (
    input  logic                CLK,
    input  logic                nRST,
    dramstore_arbiter_if.master bus
`ifdef DRAMSTORE_ARB_PERF_EN
    ,
    output logic [31:0]         perf_stores,
    output logic [31:0]         perf_stall
`endif
);

    dsarb_state_t       state_r, state_nxt_s;
    logic [1:0]         rr_ptr_r, rr_ptr_nxt_s, last_grant_r, ptr_sel_s;
    logic               sstore_r, pop_s;
    logic [ADDR_W-1:0]  store_addr_r;
    logic [DATA_W-1:0]  store_data_r;
    logic [3:0]         gnt_onehot_s;
    logic [1:0]         gnt_idx_s;
    logic               gnt_any_s;
    logic [REC_W-1:0]   rec_raw_s;
    dramstore_rec_t     rec_s;
    logic               unused_rsvd_s;

    // On a retiring store the next grant already searches from last_grant+1.
    assign ptr_sel_s = (state_r == BUSY && bus.sStore_hit) ? (last_grant_r + 2'd1) : rr_ptr_r;

    rr_arbiter4 u_rr (
        .req        (~bus.fifo_empty),
        .ptr        (ptr_sel_s),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s),
        .any        (gnt_any_s)
    );

    assign rec_raw_s     = bus.fifo_rdata[gnt_idx_s];
    assign rec_s         = dramstore_rec_t'(rec_raw_s);
    assign unused_rsvd_s = ^rec_s.rsvd;

    // Next-state, pointer update and pop decision.
    always_comb begin
        state_nxt_s  = state_r;
        rr_ptr_nxt_s = rr_ptr_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_any_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.sStore_hit) begin
                    rr_ptr_nxt_s = ptr_sel_s;
                    if (gnt_any_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = BUSY;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pops are suppressed while reset is asserted so no record is lost then.
    assign bus.fifo_REN = (pop_s && nRST) ? gnt_onehot_s : 4'b0000;

    // FSM, pointer and latched store registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r      <= IDLE;
            rr_ptr_r     <= 2'd0;
            last_grant_r <= 2'd0;
            sstore_r     <= 1'b0;
            store_addr_r <= {ADDR_W{1'b0}};
            store_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            sstore_r <= (state_nxt_s == BUSY);
            if (pop_s) begin
                last_grant_r <= gnt_idx_s;
                store_addr_r <= ADDR_W'(calc_store_addr(rec_s.addr, rec_s.row));
                store_data_r <= DATA_W'(rec_s.data);
            end
        end
    end

    assign bus.sStore     = sstore_r;
    assign bus.store_addr = store_addr_r;
    assign bus.store_data = store_data_r;

`ifdef DRAMSTORE_ARB_PERF_EN
    logic [31:0] perf_stores_r, perf_stall_r;

    // Retired-store and stalled-cycle counters, wrapping at 2^32.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_stores_r <= 32'd0;
            perf_stall_r  <= 32'd0;
        end else if (state_r == BUSY) begin
            if (bus.sStore_hit) begin
                perf_stores_r <= perf_stores_r + 32'd1;
            end else begin
                perf_stall_r  <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_stores = perf_stores_r;
    assign perf_stall  = perf_stall_r;
`endif

endmodule

// File: doc/dramstore_arbiter.md
# dramstore_arbiter

Round-robin scheduler that drains the four per-row DRAM store FIFOs into the single scratchpad-to-DRAM store port. It replaces fixed-priority draining with a registered, fair, one-outstanding-store sequencer. For each record it pops the winning FIFO, computes the strided row address, and holds `sStore` with stable address and data until `sStore_hit` retires the store. It sits between the dramFIFO0..3 instances and the memory-side store interface of the scratchpad.

## Interface
Parameters:
- `ADDR_W`, 32, store address width.
- `DATA_W`, 64, store data width.
- `REC_W`, 100, FIFO record width. Fields: [99:68] base address, [67:66] reserved, [65:64] row index, [63:0] data.

Ports:
- `CLK`  in  1  clock; all state on rising edge.
- `nRST`  in  1  reset; asynchronous, active-low.
- `fifo_empty`  in  4  bit i = dramFIFOi empty.
- `fifo_rdata`  in  4×REC_W  show-ahead head record of each FIFO.
- `fifo_REN`  out  4  one-hot pop strobe, at most one bit high per cycle.
- `sStore_hit`  in  1  memory accepted the current store this cycle.
- `sStore`  out  1  store request valid.
- `store_addr`  out  ADDR_W  registered store address.
- `store_data`  out  DATA_W  registered store data.

## Operation
- States:
  - IDLE: no store held.
  - BUSY: one latched store presented.
- Request vector: `req = ~fifo_empty`.
- Round-robin pointer `rr_ptr` (2 bits). The grant is the first set bit of `req` searching from `rr_ptr` upward, wrapping 3 to 0.
- IDLE with `req != 0`:
  - Assert `fifo_REN[grant]`, combinationally, in the same cycle.
  - Latch `store_addr = rec[99:68] + STRIDE * rec[65:64]` and `store_data = rec[63:0]` from the granted FIFO's own record.
  - Go to BUSY.
- BUSY with `sStore_hit = 0`:
  - Hold addr and data stable.
  - `fifo_REN = 0`.
- BUSY with `sStore_hit = 1`:
  - Set `rr_ptr = last_grant + 1` (mod 4).
  - If `req != 0`, grant is computed from the updated pointer. Pop and latch the next record in the same cycle and stay in BUSY (back-to-back).
  - Otherwise go to IDLE.
- `sStore = (state == BUSY)`.
- `sStore_hit` in IDLE is ignored.
- Address arithmetic:
  - `STRIDE` comes from `types_pkg`.
  - The product is computed at ADDR_W, and the sum is truncated to ADDR_W (wraps modulo 2^32).
  - Reserved bits [67:66] are ignored.
- A FIFO that goes empty while its record is latched has no effect; the record was already popped.

## Timing
- Reset, asynchronous on `nRST` low:
  - state = IDLE, `rr_ptr = 0`, `last_grant = 0`.
  - `sStore = 0`, `store_addr = 0`, `store_data = 0`.
  - `fifo_REN = 0`.
- Reset mid-store drops the latched record. The popped record is lost by design; upstream flushes on reset too.
- Latency: FIFO non-empty in IDLE at cycle N gives REN at cycle N and `sStore` high from cycle N+1.
- Throughput: one store per cycle when `sStore_hit` is held high and requests are continuous.
- Fairness: with all four FIFOs non-empty, grants go 0,1,2,3,0,… and no FIFO waits more than 3 stores.
- `fifo_REN` is only ever asserted for a FIFO whose `fifo_empty` is 0 in that cycle.

## Configuration
- `DRAMSTORE_ARB_PERF_EN` defined adds two outputs:
  - `perf_stores` (32 bits): increments on each `sStore_hit` in BUSY.
  - `perf_stall` (32 bits): increments on each BUSY cycle with `sStore_hit = 0`.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent. The remaining behaviour is identical.

## Structure
- `types_pkg`:
  - `STRIDE`.
  - `dramstore_rec_t` packed struct {addr[31:0], rsvd[1:0], row[1:0], data[63:0]}.
  - `dsarb_state_t` enum {IDLE, BUSY}.
- Sub-module `rr_arbiter4`:
  - Combinational. Inputs `req[3:0]`, `ptr[1:0]`; outputs `gnt_onehot[3:0]`, `gnt_idx[1:0]`, `any`.
  - Instantiated once; the top holds the FSM, pointer and data registers.

## Test plan
- Reset, then FIFO2 alone holds {addr=0x1000_0000, row=3, data=0xDEAD_BEEF_0000_0001}, with `sStore_hit` arriving 2 cycles after `sStore` rises:
  - `fifo_REN = 0100` for one cycle.
  - `sStore = 1` with `store_addr = 0x1000_0000 + 3*STRIDE`, data exact, held 3 cycles.
  - Return to IDLE.
- All four FIFOs hold 2 records each, `sStore_hit` tied high:
  - Grant order 0,1,2,3,0,1,2,3.
  - 8 consecutive `sStore` cycles with no bubble.
  - Then IDLE.
- `sStore_hit` held low for 10 cycles while other FIFOs fill:
  - Addr and data are stable.
  - `fifo_REN = 0` throughout.
  - With PERF_EN, `perf_stall = 10`.
- Address wrap: base 0xFFFF_FFF0, row 1, STRIDE ≥ 0x10 → the truncated 32-bit sum is checked.
- `nRST` pulsed low while BUSY:
  - Outputs are 0 immediately (asynchronous).
  - `rr_ptr = 0`, and the next grant is the lowest non-empty FIFO.
- Random empty/hit stimulus, 10k cycles, with a scoreboard:
  - Every popped record appears exactly once on the store port.
  - REN is never asserted on an empty FIFO.
